// File: rtl/window_gen_kxk_stream_if.sv
// Stream bundle for the KxK window generator: pixel input side, window output side,
// and the frame error pulse. The generator uses the slave modport, the producer/consumer
// pair (or a bench) uses the master modport.
interface window_gen_kxk_stream_if #(
  parameter int PIX_W = 9,
  parameter int K     = 3,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sof;
  logic signed [PIX_W-1:0] in_pixel;
  logic                    out_valid;
  logic                    out_ready;
  logic [K*K*PIX_W-1:0]    win_flat;
  logic [XW-1:0]           out_x;
  logic [YW-1:0]           out_y;
  logic                    out_last;
  logic                    frame_err;

  modport master (
    output in_valid, in_sof, in_pixel, out_ready,
    input  in_ready, out_valid, win_flat, out_x, out_y, out_last, frame_err
  );

  modport slave (
    input  in_valid, in_sof, in_pixel, out_ready,
    output in_ready, out_valid, win_flat, out_x, out_y, out_last, frame_err
  );
endinterface

// File: rtl/window_gen_kxk_stream.sv
// KxK raster window generator with ready/valid backpressure, start-of-frame resync,
// frame wrap and last-window marker. Pixels are forwarded bit-exact.
// Optional build macro WINGEN_STRIDE2_EN: only windows whose top-left x and y are both
// even are emitted; storage and counters behave identically in both builds.
module window_gen_kxk_stream #(
  parameter int PIX_W = 9,
  parameter int K     = 3,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input logic                    clk,
  input logic                    rst,
  window_gen_kxk_stream_if.slave bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int WW = K * K * PIX_W;

`ifdef WINGEN_STRIDE2_EN
  localparam int LAST_XI = ((IMG_W - K) / 2) * 2;
  localparam int LAST_YI = ((IMG_H - K) / 2) * 2;
`else
  localparam int LAST_XI = IMG_W - K;
  localparam int LAST_YI = IMG_H - K;
`endif

  localparam logic [XW-1:0] X_MAX   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_START = XW'(K - 1);
  localparam logic [YW-1:0] Y_START = YW'(K - 1);
  localparam logic [XW-1:0] LAST_X  = XW'(LAST_XI);
  localparam logic [YW-1:0] LAST_Y  = YW'(LAST_YI);

  logic [XW-1:0]    x, cur_x, win_x;
  logic [YW-1:0]    y, cur_y, win_y;
  logic             accept, resync, emit, win_last;
  logic [PIX_W-1:0] line_buf [K-1][IMG_W];
  logic [PIX_W-1:0] col_sr   [K][K];
  logic [PIX_W-1:0] new_col  [K];
  logic [WW-1:0]    win_next;

  // A new pixel may enter whenever the output register is empty or being drained now.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;

  // Resolve where the incoming pixel lands (in_sof forces (0,0)) and build the window it completes.
  always_comb begin
    accept   = bus.in_valid && bus.in_ready;
    resync   = accept && bus.in_sof && ((x != '0) || (y != '0));
    cur_x    = bus.in_sof ? '0 : x;
    cur_y    = bus.in_sof ? '0 : y;
    win_x    = cur_x - X_START;
    win_y    = cur_y - Y_START;
    win_next = '0;
    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = line_buf[K-2-r][cur_x];
    end
    new_col[K-1] = bus.in_pixel;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_next[(r*K+c)*PIX_W +: PIX_W] = col_sr[r][c+1];
      end
      win_next[(r*K+K-1)*PIX_W +: PIX_W] = new_col[r];
    end
`ifdef WINGEN_STRIDE2_EN
    emit = accept && (cur_x >= X_START) && (cur_y >= Y_START) && !win_x[0] && !win_y[0];
`else
    emit = accept && (cur_x >= X_START) && (cur_y >= Y_START);
`endif
    win_last = (win_x == LAST_X) && (win_y == LAST_Y);
  end

  // Raster position advances once per accepted pixel, wrapping at line end and frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (cur_x == X_MAX) begin
        x <= '0;
        y <= (cur_y == Y_MAX) ? '0 : cur_y + YW'(1);
      end else begin
        x <= cur_x + XW'(1);
        y <= cur_y;
      end
    end
  end

  // Line buffers age by one line at the current column; line 0 always holds the newest row.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[0][cur_x] <= bus.in_pixel;
      for (int j = 1; j < K - 1; j++) begin
        line_buf[j][cur_x] <= line_buf[j-1][cur_x];
      end
    end
  end

  // Column shift registers slide left and take the freshly assembled column on the right.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          col_sr[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          col_sr[r][c] <= col_sr[r][c+1];
        end
        col_sr[r][K-1] <= new_col[r];
      end
    end
  end

  // Output register: load a completed window, hold it under backpressure, clear on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.win_flat  <= '0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
      bus.out_last  <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= resync;
      if (emit) begin
        bus.out_valid <= 1'b1;
        bus.win_flat  <= win_next;
        bus.out_x     <= win_x;
        bus.out_y     <= win_y;
        bus.out_last  <= win_last;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_window_gen_kxk_stream.sv
// Bench for window_gen_kxk_stream (K=3, 8x8, 9-bit pixels). An image-level model predicts
// every output each cycle; literal windows pin the model. Honours WINGEN_STRIDE2_EN.
module tb_window_gen_kxk_stream;
  localparam int PIX_W = 9;
  localparam int K     = 3;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int WW    = K * K * PIX_W;

`ifdef WINGEN_STRIDE2_EN
  localparam int WPF     = 9;
  localparam int LAST_XY = 4;
  localparam int STALL_X = 2, STALL_Y = 2, NEXT_X = 4, NEXT_Y = 2;
  localparam logic [WW-1:0] W_LAST = {9'd54, 9'd53, 9'd52, 9'd46, 9'd45, 9'd44, 9'd38, 9'd37, 9'd36};
`else
  localparam int WPF     = 36;
  localparam int LAST_XY = 5;
  localparam int STALL_X = 3, STALL_Y = 1, NEXT_X = 4, NEXT_Y = 1;
  localparam logic [WW-1:0] W_LAST = {9'd63, 9'd62, 9'd61, 9'd55, 9'd54, 9'd53, 9'd47, 9'd46, 9'd45};
`endif
  localparam logic [WW-1:0] W_FIRST = {9'd18, 9'd17, 9'd16, 9'd10, 9'd9, 9'd8, 9'd2, 9'd1, 9'd0};

  typedef struct {
    logic [WW-1:0] win;
    int            x;
    int            y;
    logic          last;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   err_count = 0;
  bit   started = 0;
  bit   stall_armed = 0;
  int   stall_cnt = 0;
  win_t log_q[$];

  // model state
  logic [PIX_W-1:0] img [IMG_H][IMG_W];
  int               mx = 0, my = 0;
  bit               m_valid = 0, m_err = 0, m_last = 0;
  logic [WW-1:0]    m_win = '0;
  int               m_x = 0, m_y = 0;

  window_gen_kxk_stream_if #(.PIX_W(PIX_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

  window_gen_kxk_stream #(.PIX_W(PIX_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit stride_ok(input int wx, input int wy);
`ifdef WINGEN_STRIDE2_EN
    return (wx % 2 == 0) && (wy % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  // Image-level model: stores each accepted pixel at its raster position and cuts windows from it.
  always @(posedge clk) begin
    bit acc, load;
    if (rst) begin
      mx = 0; my = 0; m_valid = 0; m_err = 0; m_win = '0; m_x = 0; m_y = 0; m_last = 0;
    end else begin
      acc   = bus.in_valid && (!m_valid || bus.out_ready);
      load  = 0;
      m_err = 0;
      if (acc) begin
        if (bus.in_sof && (mx != 0 || my != 0)) m_err = 1;
        if (bus.in_sof) begin mx = 0; my = 0; end
        img[my][mx] = bus.in_pixel;
        if (mx >= K - 1 && my >= K - 1 && stride_ok(mx - K + 1, my - K + 1)) begin
          load = 1;
          m_x  = mx - K + 1;
          m_y  = my - K + 1;
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              m_win[(r*K+c)*PIX_W +: PIX_W] = img[m_y + r][m_x + c];
          m_last = (m_x == LAST_XY) && (m_y == LAST_XY);
        end
        mx++;
        if (mx == IMG_W) begin
          mx = 0;
          my = (my == IMG_H - 1) ? 0 : my + 1;
        end
      end
      if (load) m_valid = 1;
      else if (bus.out_ready) m_valid = 0;
    end
  end

  // Compare every visible output against the model and log completed handshakes.
  always @(negedge clk) begin
    if (started && !rst) begin
      check_output("in_ready", 128'(bus.in_ready), 128'(!m_valid || bus.out_ready));
      check_output("out_valid", 128'(bus.out_valid), 128'(m_valid));
      check_output("frame_err", 128'(bus.frame_err), 128'(m_err));
      if (m_valid) begin
        check_output("win_flat", 128'(bus.win_flat), 128'(m_win));
        check_output("out_x", 128'(bus.out_x), 128'(m_x));
        check_output("out_y", 128'(bus.out_y), 128'(m_y));
        check_output("out_last", 128'(bus.out_last), 128'(m_last));
      end
      if (bus.out_valid && bus.out_ready)
        log_q.push_back('{win: bus.win_flat, x: int'(bus.out_x), y: int'(bus.out_y), last: bus.out_last});
      if (bus.frame_err) err_count++;
    end
  end

  // Backpressure injector: holds out_ready low for 5 edges once the target window shows up.
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      stall_cnt--;
      if (stall_cnt == 0) bus.out_ready = 1'b1;
    end else if (stall_armed && bus.out_valid && int'(bus.out_x) == STALL_X && int'(bus.out_y) == STALL_Y) begin
      bus.out_ready = 1'b0;
      stall_cnt     = 5;
      stall_armed   = 0;
    end
  end

  // Offer one pixel and wait (bounded) until it is accepted.
  task automatic apply_stimulus(input logic [PIX_W-1:0] pix, input logic sof);
    bit rdy;
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_pixel = pix;
    bus.in_sof   = sof;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      fails++;
      tests++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 200 cycles");
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int sgn, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(PIX_W'(sgn * i), i == 0);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    bit same;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1;
    check_output("reset_out_valid", 128'(bus.out_valid), 128'(0));
    check_output("reset_win_flat", 128'(bus.win_flat), 128'(0));
    check_output("reset_out_x", 128'(bus.out_x), 128'(0));
    check_output("reset_out_y", 128'(bus.out_y), 128'(0));
    check_output("reset_out_last", 128'(bus.out_last), 128'(0));
    check_output("reset_frame_err", 128'(bus.frame_err), 128'(0));

    // one frame, with a 5-cycle stall on one window
    $display("[TB] frame with backpressure");
    log_q.delete();
    stall_armed = 1;
    send_frame(1, 64);
    drain();
    check_output("count_frame1", 128'(log_q.size()), 128'(WPF));
    if (log_q.size() == WPF) begin
      check_output("first_win", 128'(log_q[0].win), 128'(W_FIRST));
      check_output("first_xy", 128'({log_q[0].x, log_q[0].y}), 128'(0));
      check_output("last_win", 128'(log_q[WPF-1].win), 128'(W_LAST));
      check_output("last_x", 128'(log_q[WPF-1].x), 128'(LAST_XY));
      check_output("last_y", 128'(log_q[WPF-1].y), 128'(LAST_XY));
      check_output("last_flag", 128'(log_q[WPF-1].last), 128'(1));
      idx = -1;
      for (int i = 0; i < WPF - 1; i++)
        if (log_q[i].x == STALL_X && log_q[i].y == STALL_Y) idx = i;
      check_output("stall_win_found", 128'(idx >= 0), 128'(1));
      if (idx >= 0) begin
        check_output("after_stall_x", 128'(log_q[idx+1].x), 128'(NEXT_X));
        check_output("after_stall_y", 128'(log_q[idx+1].y), 128'(NEXT_Y));
      end
    end

    // two back-to-back negative frames
    $display("[TB] two negative frames");
    log_q.delete();
    send_frame(-1, 64);
    send_frame(-1, 64);
    drain();
    check_output("count_two_frames", 128'(log_q.size()), 128'(2 * WPF));
    if (log_q.size() == 2 * WPF) begin
      same = 1;
      for (int i = 0; i < WPF; i++)
        if (log_q[i].win !== log_q[i+WPF].win || log_q[i].x != log_q[i+WPF].x || log_q[i].y != log_q[i+WPF].y)
          same = 0;
      check_output("frames_identical", 128'(same), 128'(1));
      check_output("neg18_slot8", 128'(log_q[0].win[8*PIX_W +: PIX_W]), 128'(9'h1EE));
      check_output("neg0_slot0", 128'(log_q[0].win[0 +: PIX_W]), 128'(9'h000));
    end

    // in_sof on pixel (4,3) restarts the frame
    $display("[TB] sof resync");
    err_count = 0;
    send_frame(1, 28);
    drain();
    log_q.delete();
    send_frame(1, 64);
    drain();
    check_output("frame_err_pulses", 128'(err_count), 128'(1));
    check_output("count_after_resync", 128'(log_q.size()), 128'(WPF));
    if (log_q.size() > 0) begin
      check_output("resync_first_win", 128'(log_q[0].win), 128'(W_FIRST));
      check_output("resync_first_xy", 128'({log_q[0].x, log_q[0].y}), 128'(0));
    end

    // reset while a window is stalled
    $display("[TB] reset during stall");
    bus.out_ready = 1'b0;
    send_frame(1, 19);
    repeat (2) @(posedge clk);
    #1;
    check_output("stalled_valid", 128'(bus.out_valid), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_output("post_rst_valid", 128'(bus.out_valid), 128'(0));
    check_output("post_rst_x", 128'(bus.out_x), 128'(0));
    check_output("post_rst_y", 128'(bus.out_y), 128'(0));
    bus.out_ready = 1'b1;
    log_q.delete();
    send_frame(1, 64);
    drain();
    check_output("count_after_rst", 128'(log_q.size()), 128'(WPF));
    if (log_q.size() > 0)
      check_output("rst_first_win", 128'(log_q[0].win), 128'(W_FIRST));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
